// File: rtl/ibex_pkg.sv
// Shared PMP types for the registered PMP checker.
// Holds privilege levels, PMP region modes, access types and the region
// configuration struct. PMP_MAX_REGIONS caps the implemented region count.
package ibex_pkg;

  localparam int unsigned PMP_MAX_REGIONS = 64;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_mode_e;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef struct packed {
    logic      lock;
    pmp_mode_e mode;
    logic      exec;
    logic      write;
    logic      read;
  } pmp_cfg_t;

endpackage

// File: rtl/ibex_pmp_region_match.sv
// Combinational match of one PMP region against one access address.
// Ports:
//   addr        access byte address
//   req_type    exec/read/write
//   cfg         region configuration
//   region_addr region byte address (bits [1:0] ignored)
//   prev_addr   previous region's address, TOR lower bound (0 for region 0)
//   match       address falls in the region
//   perm_ok     region grants the requested access type
//   lock        region lock bit
module ibex_pmp_region_match
  import ibex_pkg::*;
#(
  parameter int unsigned AddrWidth   = 34,
  parameter int unsigned Granularity = 0
) (
  input  logic [AddrWidth-1:0] addr,
  input  pmp_req_e             req_type,
  input  pmp_cfg_t             cfg,
  input  logic [AddrWidth-1:0] region_addr,
  input  logic [AddrWidth-1:0] prev_addr,
  output logic                 match,
  output logic                 perm_ok,
  output logic                 lock
);

  localparam int unsigned FieldW = AddrWidth - 2;
  localparam int unsigned Lsb    = Granularity + 2;

  logic [FieldW-1:0]      addr_field;
  logic [FieldW-1:0]      region_field;
  logic [FieldW-1:0]      napot_mask;
  logic [AddrWidth-1:Lsb] addr_cmp;
  logic [AddrWidth-1:Lsb] region_cmp;
  logic [AddrWidth-1:Lsb] prev_cmp;
  logic                   unused_bits;

  assign addr_field   = addr[AddrWidth-1:2];
  assign region_field = region_addr[AddrWidth-1:2];
  assign addr_cmp     = addr[AddrWidth-1:Lsb];
  assign region_cmp   = region_addr[AddrWidth-1:Lsb];
  assign prev_cmp     = prev_addr[AddrWidth-1:Lsb];
  assign unused_bits  = ^{addr[1:0], region_addr[1:0], prev_addr[Lsb-1:0]};

  // A field bit takes part in the NAPOT compare only when some bit below it
  // is zero: the trailing-ones run plus the first zero are all "don't care".
  // Bits under the granule are always ignored.
  always_comb begin : napot_mask_gen
    logic below_ones;
    below_ones = 1'b1;
    napot_mask = '0;
    for (int b = 0; b < FieldW; b++) begin
      napot_mask[b] = (b >= Granularity) && !below_ones;
      below_ones    = below_ones & region_field[b];
    end
  end

  always_comb begin
    match = 1'b0;
    case (cfg.mode)
      PMP_MODE_NA4:   match = (addr_cmp == region_cmp);
      PMP_MODE_NAPOT: match = (((addr_field ^ region_field) & napot_mask) == '0);
      PMP_MODE_TOR:   match = (prev_cmp < region_cmp) && (prev_cmp <= addr_cmp) &&
                              (addr_cmp < region_cmp);
      default:        match = 1'b0;
    endcase
  end

  assign perm_ok = ((req_type == PMP_ACC_EXEC)  & cfg.exec)  |
                   ((req_type == PMP_ACC_WRITE) & cfg.write) |
                   ((req_type == PMP_ACC_READ)  & cfg.read);
  assign lock    = cfg.lock;

endmodule

// File: rtl/ibex_pmp_pipe.sv
// Registered, handshaked PMP checker with per-channel skid stage (latency 1),
// MMWP default-deny, matched-region index and sticky first-fault capture.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   setback_i              synchronous flush of all state
//   csr_pmp_cfg_i/addr_i   region configs and byte addresses
//   csr_mmwp_i             M-mode no-match denies
//   req_*                  per-channel request (valid/ready/addr/type/priv)
//   rsp_*                  per-channel result (valid/ready/err/match/region)
//   fault_*                captured first fault, fault_clear_i clears it
module ibex_pmp_pipe
  import ibex_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumChan     = 2,
  parameter int unsigned PMPNumRegions  = 16,
  parameter int unsigned PMPAddrWidth   = 34,
  localparam int unsigned RegW  = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1,
  localparam int unsigned ChanW = $clog2((PMPNumChan > 2) ? PMPNumChan : 2)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      setback_i,
  input  pmp_cfg_t [PMPNumRegions-1:0]              csr_pmp_cfg_i,
  input  logic [PMPNumRegions-1:0][PMPAddrWidth-1:0] csr_pmp_addr_i,
  input  logic                                      csr_mmwp_i,
  input  logic [PMPNumChan-1:0]                     req_valid_i,
  output logic [PMPNumChan-1:0]                     req_ready_o,
  input  logic [PMPNumChan-1:0][PMPAddrWidth-1:0]   req_addr_i,
  input  pmp_req_e [PMPNumChan-1:0]                 req_type_i,
  input  priv_lvl_e [PMPNumChan-1:0]                req_priv_i,
  output logic [PMPNumChan-1:0]                     rsp_valid_o,
  input  logic [PMPNumChan-1:0]                     rsp_ready_i,
  output logic [PMPNumChan-1:0]                     rsp_err_o,
  output logic [PMPNumChan-1:0]                     rsp_match_o,
  output logic [PMPNumChan-1:0][RegW-1:0]           rsp_region_o,
  output logic                                      fault_valid_o,
  output logic [PMPAddrWidth-1:0]                   fault_addr_o,
  output logic [ChanW-1:0]                          fault_chan_o,
  output pmp_req_e                                  fault_type_o,
  input  logic                                      fault_clear_i
);

  if (PMPNumRegions < 1 || PMPNumRegions > PMP_MAX_REGIONS) begin : g_bad_regions
    $error("PMPNumRegions out of range");
  end

  logic [PMPNumRegions-1:0][PMPAddrWidth-1:0] prev_addr;
  logic [PMPNumChan-1:0][PMPNumRegions-1:0]   reg_match, reg_perm, reg_lock;
  logic [PMPNumChan-1:0]                      chk_match, chk_err, hit_perm, hit_lock;
  logic [PMPNumChan-1:0][RegW-1:0]            chk_region;
  logic [PMPNumChan-1:0]                      accept;
  logic                                       new_fault;
  logic [ChanW-1:0]                           new_chan;
  logic [PMPAddrWidth-1:0]                    new_addr;
  pmp_req_e                                   new_type;

  for (genvar r = 0; r < PMPNumRegions; r++) begin : g_prev
    if (r == 0) begin : g_first
      assign prev_addr[r] = '0;
    end else begin : g_rest
      assign prev_addr[r] = csr_pmp_addr_i[r-1];
    end
  end

  for (genvar c = 0; c < PMPNumChan; c++) begin : g_chan
    for (genvar r = 0; r < PMPNumRegions; r++) begin : g_region
      ibex_pmp_region_match #(
        .AddrWidth   (PMPAddrWidth),
        .Granularity (PMPGranularity)
      ) u_match (
        .addr        (req_addr_i[c]),
        .req_type    (req_type_i[c]),
        .cfg         (csr_pmp_cfg_i[r]),
        .region_addr (csr_pmp_addr_i[r]),
        .prev_addr   (prev_addr[r]),
        .match       (reg_match[c][r]),
        .perm_ok     (reg_perm[c][r]),
        .lock        (reg_lock[c][r])
      );
    end
  end

  // Priority encode: scanning downward leaves the lowest matching region.
  always_comb begin
    chk_match  = '0;
    chk_region = '0;
    chk_err    = '0;
    hit_perm   = '0;
    hit_lock   = '0;
    for (int c = 0; c < PMPNumChan; c++) begin
      for (int r = PMPNumRegions - 1; r >= 0; r--) begin
        if (reg_match[c][r]) begin
          chk_match[c]  = 1'b1;
          chk_region[c] = RegW'(r);
          hit_perm[c]   = reg_perm[c][r];
          hit_lock[c]   = reg_lock[c][r];
        end
      end
      if (req_priv_i[c] == PRIV_LVL_M) begin
        chk_err[c] = chk_match[c] ? (hit_lock[c] & ~hit_perm[c]) : csr_mmwp_i;
      end else begin
        chk_err[c] = chk_match[c] ? ~hit_perm[c] : 1'b1;
      end
    end
  end

  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign accept      = req_valid_i & req_ready_o;

  // Lowest faulting channel wins when several fault together.
  always_comb begin
    new_fault = 1'b0;
    new_chan  = '0;
    new_addr  = '0;
    new_type  = PMP_ACC_EXEC;
    for (int c = PMPNumChan - 1; c >= 0; c--) begin
      if (accept[c] && chk_err[c]) begin
        new_fault = 1'b1;
        new_chan  = ChanW'(c);
        new_addr  = req_addr_i[c];
        new_type  = req_type_i[c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o   <= '0;
      rsp_err_o     <= '0;
      rsp_match_o   <= '0;
      rsp_region_o  <= '0;
      fault_valid_o <= 1'b0;
      fault_addr_o  <= '0;
      fault_chan_o  <= '0;
      fault_type_o  <= PMP_ACC_EXEC;
    end else if (setback_i) begin
      rsp_valid_o   <= '0;
      rsp_err_o     <= '0;
      rsp_match_o   <= '0;
      rsp_region_o  <= '0;
      fault_valid_o <= 1'b0;
      fault_addr_o  <= '0;
      fault_chan_o  <= '0;
      fault_type_o  <= PMP_ACC_EXEC;
    end else begin
      for (int c = 0; c < PMPNumChan; c++) begin
        if (accept[c]) begin
          rsp_valid_o[c]  <= 1'b1;
          rsp_err_o[c]    <= chk_err[c];
          rsp_match_o[c]  <= chk_match[c];
          rsp_region_o[c] <= chk_region[c];
        end else if (rsp_ready_i[c]) begin
          rsp_valid_o[c]  <= 1'b0;
        end
      end
      // A clear in the same cycle as a new fault still lets the new one in.
      if (new_fault && (!fault_valid_o || fault_clear_i)) begin
        fault_valid_o <= 1'b1;
        fault_addr_o  <= new_addr;
        fault_chan_o  <= new_chan;
        fault_type_o  <= new_type;
      end else if (fault_clear_i) begin
        fault_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ibex_pmp_pipe.sv
module tb_ibex_pmp_pipe;
  import ibex_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  setback = 1'b0;
  pmp_cfg_t [15:0]       csr_cfg;
  logic [15:0][33:0]     csr_addr;
  logic                  mmwp = 1'b0;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [1:0][33:0]      req_addr = '0;
  pmp_req_e [1:0]        req_type;
  priv_lvl_e [1:0]       req_priv;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready = '0;
  logic [1:0]            rsp_err;
  logic [1:0]            rsp_match;
  logic [1:0][3:0]       rsp_region;
  logic                  fault_valid;
  logic [33:0]           fault_addr;
  logic [0:0]            fault_chan;
  pmp_req_e              fault_type;
  logic                  fault_clear = 1'b0;
  logic [51:0]           all_out;

  int cnt_run = 0;
  int cnt_fail = 0;

  ibex_pmp_pipe dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .setback_i      (setback),
    .csr_pmp_cfg_i  (csr_cfg),
    .csr_pmp_addr_i (csr_addr),
    .csr_mmwp_i     (mmwp),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_type_i     (req_type),
    .req_priv_i     (req_priv),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_err_o      (rsp_err),
    .rsp_match_o    (rsp_match),
    .rsp_region_o   (rsp_region),
    .fault_valid_o  (fault_valid),
    .fault_addr_o   (fault_addr),
    .fault_chan_o   (fault_chan),
    .fault_type_o   (fault_type),
    .fault_clear_i  (fault_clear)
  );

  always #5 clk = ~clk;

  assign all_out = {rsp_valid, rsp_err, rsp_match, rsp_region,
                    fault_valid, fault_addr, fault_chan, fault_type};

  function automatic logic [6:0] ch(int c);
    return {rsp_valid[c], rsp_err[c], rsp_match[c], rsp_region[c]};
  endfunction

  function automatic logic [37:0] flt();
    return {fault_valid, fault_addr, fault_chan, fault_type};
  endfunction

  function automatic pmp_cfg_t mk_cfg(logic l, pmp_mode_e m, logic x, logic w, logic r);
    return '{lock: l, mode: m, exec: x, write: w, read: r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_csr();
    for (int i = 0; i < 16; i++) begin
      csr_cfg[i]  = '0;
      csr_addr[i] = '0;
    end
  endtask

  task automatic drive(int c, logic [33:0] a, pmp_req_e t, priv_lvl_e p);
    req_valid[c] = 1'b1;
    req_addr[c]  = a;
    req_type[c]  = t;
    req_priv[c]  = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    cnt_run++; if (all_out !== '0) begin cnt_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    cnt_run++; if (req_ready !== 2'b11) begin cnt_fail++; $display("FAIL reset_ready: got %b want 11", req_ready); end
    rst_n = 1'b1;
    step(); step();
    cnt_run++; if (all_out !== '0) begin cnt_fail++; $display("FAIL idle_outputs: got %h want 0", all_out); end
    cnt_run++; if (req_ready !== 2'b11) begin cnt_fail++; $display("FAIL idle_ready: got %b want 11", req_ready); end
  endtask

  task automatic test_tor();
    clear_csr();
    csr_cfg[0]  = mk_cfg(1'b0, PMP_MODE_TOR, 1'b0, 1'b0, 1'b1);
    csr_addr[0] = 34'h1000;
    rsp_ready   = 2'b11;
    drive(0, 34'h0FFC, PMP_ACC_READ, PRIV_LVL_U);
    #1;
    cnt_run++; if (rsp_valid[0] !== 1'b0) begin cnt_fail++; $display("FAIL tor_latency: got valid %b want 0", rsp_valid[0]); end
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1010000) begin cnt_fail++; $display("FAIL tor_hit: got %b want 1010000", ch(0)); end
    drive(0, 34'h1000, PMP_ACC_READ, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1100000) begin cnt_fail++; $display("FAIL tor_top_edge: got %b want 1100000", ch(0)); end
    step();
    cnt_run++; if (rsp_valid[0] !== 1'b0) begin cnt_fail++; $display("FAIL tor_pop: got valid %b want 0", rsp_valid[0]); end
    drive(1, 34'h0FFC, PMP_ACC_READ, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (ch(1) !== 7'b1010000) begin cnt_fail++; $display("FAIL tor_ch1: got %b want 1010000", ch(1)); end
    step();
  endtask

  task automatic test_napot_priority();
    clear_csr();
    csr_cfg[0]  = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b0, 1'b0, 1'b0);
    csr_addr[0] = 34'h207C;
    csr_cfg[1]  = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b1, 1'b1, 1'b1);
    csr_addr[1] = 34'h7FFC;
    drive(0, 34'h2010, PMP_ACC_WRITE, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1110000) begin cnt_fail++; $display("FAIL napot_prio_r0: got %b want 1110000", ch(0)); end
    drive(0, 34'h3000, PMP_ACC_WRITE, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1010001) begin cnt_fail++; $display("FAIL napot_r1: got %b want 1010001", ch(0)); end
    drive(0, 34'h10000, PMP_ACC_READ, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1100000) begin cnt_fail++; $display("FAIL napot_outside: got %b want 1100000", ch(0)); end
    step();
  endtask

  task automatic test_mmwp_lock();
    clear_csr();
    mmwp = 1'b0;
    drive(0, 34'h8000, PMP_ACC_EXEC, PRIV_LVL_M);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1000000) begin cnt_fail++; $display("FAIL mmwp0: got %b want 1000000", ch(0)); end
    mmwp = 1'b1;
    drive(0, 34'h8000, PMP_ACC_EXEC, PRIV_LVL_M);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1100000) begin cnt_fail++; $display("FAIL mmwp1: got %b want 1100000", ch(0)); end
    mmwp = 1'b0;
    csr_cfg[0]  = mk_cfg(1'b1, PMP_MODE_NA4, 1'b0, 1'b1, 1'b1);
    csr_addr[0] = 34'h8000;
    drive(0, 34'h8000, PMP_ACC_EXEC, PRIV_LVL_M);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1110000) begin cnt_fail++; $display("FAIL lock_exec: got %b want 1110000", ch(0)); end
    drive(0, 34'h8000, PMP_ACC_READ, PRIV_LVL_M);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1010000) begin cnt_fail++; $display("FAIL lock_read: got %b want 1010000", ch(0)); end
    drive(0, 34'h8004, PMP_ACC_EXEC, PRIV_LVL_M);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1000000) begin cnt_fail++; $display("FAIL na4_miss: got %b want 1000000", ch(0)); end
    csr_cfg[0] = mk_cfg(1'b0, PMP_MODE_NA4, 1'b0, 1'b1, 1'b1);
    drive(0, 34'h8000, PMP_ACC_EXEC, PRIV_LVL_M);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1010000) begin cnt_fail++; $display("FAIL unlocked_m_exec: got %b want 1010000", ch(0)); end
    drive(0, 34'h8000, PMP_ACC_EXEC, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1110000) begin cnt_fail++; $display("FAIL unlocked_u_exec: got %b want 1110000", ch(0)); end
    step();
  endtask

  task automatic test_backpressure();
    clear_csr();
    csr_cfg[0]  = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b1, 1'b1, 1'b1);
    csr_addr[0] = 34'h7FFC;
    rsp_ready   = 2'b00;
    drive(0, 34'h100, PMP_ACC_READ, PRIV_LVL_U);
    step();
    drive(0, 34'h20000, PMP_ACC_READ, PRIV_LVL_U);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) csr_cfg[0] = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b0, 1'b0, 1'b0);
      cnt_run++; if (req_ready[0] !== 1'b0) begin cnt_fail++; $display("FAIL bp_ready cycle %0d: got %b want 0", i, req_ready[0]); end
      cnt_run++; if (ch(0) !== 7'b1010000) begin cnt_fail++; $display("FAIL bp_hold cycle %0d: got %b want 1010000", i, ch(0)); end
      step();
    end
    csr_cfg[0] = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b1, 1'b1, 1'b1);
    cnt_run++; if (req_ready[1] !== 1'b1) begin cnt_fail++; $display("FAIL bp_ch1_independent: got %b want 1", req_ready[1]); end
    rsp_ready[0] = 1'b1;
    #1;
    cnt_run++; if (req_ready[0] !== 1'b1) begin cnt_fail++; $display("FAIL bp_release_ready: got %b want 1", req_ready[0]); end
    step();
    cnt_run++; if (ch(0) !== 7'b1100000) begin cnt_fail++; $display("FAIL b2b_first: got %b want 1100000", ch(0)); end
    drive(0, 34'h300, PMP_ACC_READ, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (ch(0) !== 7'b1010000) begin cnt_fail++; $display("FAIL b2b_second: got %b want 1010000", ch(0)); end
    step();
    cnt_run++; if (rsp_valid[0] !== 1'b0) begin cnt_fail++; $display("FAIL b2b_drain: got %b want 0", rsp_valid[0]); end
    rsp_ready = 2'b11;
  endtask

  task automatic test_fault_capture();
    setback = 1'b1;
    step();
    setback = 1'b0;
    cnt_run++; if (all_out !== '0) begin cnt_fail++; $display("FAIL setback_clean: got %h want 0", all_out); end
    clear_csr();
    mmwp = 1'b0;
    rsp_ready = 2'b11;
    drive(0, 34'hA0, PMP_ACC_READ, PRIV_LVL_U);
    drive(1, 34'hB0, PMP_ACC_WRITE, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (flt() !== {1'b1, 34'hA0, 1'b0, PMP_ACC_READ}) begin cnt_fail++; $display("FAIL fault_simul: got %h want %h", flt(), {1'b1, 34'hA0, 1'b0, PMP_ACC_READ}); end
    drive(1, 34'hD0, PMP_ACC_EXEC, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (flt() !== {1'b1, 34'hA0, 1'b0, PMP_ACC_READ}) begin cnt_fail++; $display("FAIL fault_sticky: got %h want %h", flt(), {1'b1, 34'hA0, 1'b0, PMP_ACC_READ}); end
    fault_clear = 1'b1;
    drive(1, 34'hC0, PMP_ACC_WRITE, PRIV_LVL_U);
    step(); req_valid = '0; fault_clear = 1'b0;
    cnt_run++; if (flt() !== {1'b1, 34'hC0, 1'b1, PMP_ACC_WRITE}) begin cnt_fail++; $display("FAIL fault_clear_new: got %h want %h", flt(), {1'b1, 34'hC0, 1'b1, PMP_ACC_WRITE}); end
    fault_clear = 1'b1;
    step(); fault_clear = 1'b0;
    cnt_run++; if (fault_valid !== 1'b0) begin cnt_fail++; $display("FAIL fault_clear_only: got %b want 0", fault_valid); end
    drive(0, 34'hE0, PMP_ACC_READ, PRIV_LVL_U);
    step(); req_valid = '0;
    cnt_run++; if (flt() !== {1'b1, 34'hE0, 1'b0, PMP_ACC_READ}) begin cnt_fail++; $display("FAIL fault_recapture: got %h want %h", flt(), {1'b1, 34'hE0, 1'b0, PMP_ACC_READ}); end
    setback = 1'b1;
    drive(1, 34'hF0, PMP_ACC_READ, PRIV_LVL_U);
    step(); req_valid = '0; setback = 1'b0;
    cnt_run++; if (all_out !== '0) begin cnt_fail++; $display("FAIL setback_override: got %h want 0", all_out); end
  endtask

  task automatic test_async_reset();
    clear_csr();
    rsp_ready = 2'b00;
    drive(0, 34'h100, PMP_ACC_READ, PRIV_LVL_M);
    step(); req_valid = '0;
    cnt_run++; if (rsp_valid[0] !== 1'b1) begin cnt_fail++; $display("FAIL areset_pending: got %b want 1", rsp_valid[0]); end
    #2 rst_n = 1'b0;
    #1;
    cnt_run++; if (all_out !== '0) begin cnt_fail++; $display("FAIL areset_immediate: got %h want 0", all_out); end
    step();
    rst_n = 1'b1;
    step(); step();
    cnt_run++; if (rsp_valid !== 2'b00) begin cnt_fail++; $display("FAIL areset_discard: got %b want 00", rsp_valid); end
  endtask

  initial begin
    clear_csr();
    req_type = {PMP_ACC_READ, PMP_ACC_READ};
    req_priv = {PRIV_LVL_U, PRIV_LVL_U};
    test_reset();
    test_tor();
    test_napot_priority();
    test_mmwp_lock();
    test_backpressure();
    test_fault_capture();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", cnt_run, cnt_fail);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_pipe.md
Name: ibex_pmp_pipe

Overview:
- Registered, handshaked PMP checker. Successor to the combinational PMP checker, for cores that need PMP off the critical path.
- Channel count, region count and address width are parametrised.
- Adds an MMWP default-deny mode, a matched-region index output, and a sticky first-fault capture register for the debug/CSR path.
- Sits between the core's fetch/LSU request ports and the bus.

Parameters:
- PMPGranularity, 0, NAPOT granule (0 = 4 B, n = 2^(n+2) B).
- PMPNumChan, 2, number of independent access channels.
- PMPNumRegions, 16, implemented regions, 1..64.
- PMPAddrWidth, 34, physical address width, at least PMPGranularity+3.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- setback_i  in  1  synchronous flush of all state (lockstep resync)
- csr_pmp_cfg_i  in  ibex_pkg::pmp_cfg_t x PMPNumRegions  region configs
- csr_pmp_addr_i  in  PMPAddrWidth x PMPNumRegions  region addresses (byte, bits [1:0] ignored)
- csr_mmwp_i  in  1  machine-mode whitelist policy: M-mode no-match denies
- req_valid_i  in  PMPNumChan  request valid per channel
- req_ready_o  out  PMPNumChan  request accepted
- req_addr_i  in  PMPAddrWidth x PMPNumChan  access address
- req_type_i  in  ibex_pkg::pmp_req_e x PMPNumChan  exec/read/write
- req_priv_i  in  ibex_pkg::priv_lvl_e x PMPNumChan  privilege of access
- rsp_valid_o  out  PMPNumChan  result valid
- rsp_ready_i  in  PMPNumChan  result consumed
- rsp_err_o  out  PMPNumChan  access fault
- rsp_match_o  out  PMPNumChan  some region matched
- rsp_region_o  out  clog2(PMPNumRegions) x PMPNumChan  lowest matching region, 0 if none
- fault_valid_o  out  1  captured fault present
- fault_addr_o  out  PMPAddrWidth  captured fault address
- fault_chan_o  out  clog2(max(PMPNumChan,2))  captured fault channel
- fault_type_o  out  ibex_pkg::pmp_req_e  captured access type
- fault_clear_i  in  1  clear captured fault

Behaviour:
- Reset (rst_ni low) and setback_i: all rsp_*, fault_* outputs are 0; rsp_valid_o is 0; pipeline is empty. setback_i takes effect on the next clock edge and overrides every other event in that cycle.
- Per-channel skid stage: req_ready_o[c] = ~rsp_valid_o[c] | rsp_ready_i[c]. Accept on req_valid_i & req_ready_o. Result is registered and appears the next cycle (latency 1).
- Holding: rsp_valid_o stays high and rsp_* stay stable until rsp_ready_i is sampled high. Back-to-back throughput is 1 per cycle per channel.
- Channels are fully independent; no arbitration between them.
- The check uses CSR values in the accept cycle. A CSR change while a response is pending does not alter that response.
- Match modes:
  - OFF: never matches.
  - NA4: address[W-1:2] equals region address.
  - NAPOT: trailing ones of the address field define the mask, with the granule floor applied.
  - TOR: prev_addr <= a < addr, where prev is 0 for region 0. If prev >= addr, TOR never matches.
  - All compares use bits [W-1:PMPGranularity+2].
- Priority: lowest-index matching region determines the result. rsp_region_o gives that index.
- Permission: perm = (EXEC&x) | (WRITE&w) | (READ&r).
- Error, region matched:
  - M-mode: err = lock & ~perm.
  - Other modes: err = ~perm.
- Error, no region matched:
  - M-mode: err = csr_mmwp_i.
  - Other modes: err = 1.
- Fault capture: when an accepted request produces err=1 and fault_valid_o=0, capture addr, channel and type, and set fault_valid_o.
  - Simultaneous faults: the lowest channel wins.
  - Later faults are ignored until cleared.
  - fault_clear_i and a new fault in the same cycle: the new fault is captured.
- Asynchronous reset mid-transaction discards the in-flight result; no response is produced for it.

Decomposition:
- ibex_pkg additions: pmp_mode_e, pmp_cfg_t and pmp_req_e as already used; add localparam PMP_MAX_REGIONS=64.
- Sub-module ibex_pmp_region_match: combinational, one region by one address. Outputs match, perm_ok and lock. Instantiated PMPNumRegions x PMPNumChan times, followed by a priority encoder in the top.

Test Plan:
- Reset and idle: hold rst_ni low, then release with no requests. Required: all outputs 0, req_ready_o all 1.
- TOR basic, latency: region0 TOR addr=0x1000 with r only. U-mode read at 0x0FFC. Required: next cycle rsp_valid=1, err=0, match=1, region=0. Read at 0x1000 gives err=1, match=0.
- NAPOT priority: region0 NAPOT 0x2000/256 B with no perms; region1 NAPOT 0x0/64 KiB with rwx. U-mode write at 0x2010. Required: err=1, region=0. Write at 0x3000: err=0, region=1.
- MMWP and lock: M-mode exec at unmapped 0x8000 with mmwp=0, then mmwp=1. Required: err=0, then err=1. Locked region0 NA4 with x=0: M-mode exec errs.
- Backpressure: hold rsp_ready_i=0 after one accept. Required: req_ready_o=0 and rsp stable for 5 cycles; rsp_ready_i=1 then gives back-to-back accepts at 1 per cycle.
- Fault capture: two channels fault in the same cycle at 0xA0 and 0xB0. Required: fault_addr=0xA0, chan=0. A second fault is ignored. fault_clear_i plus a new fault at 0xC0 gives capture of 0xC0. setback_i clears all state.
